// File: rtl/rgmii_tx.sv
// RGMII transmit framer: byte stream in, preamble/SFD/payload/FCS/IPG out
// on a 4-bit DDR-style interface emulated from a single system clock.
module rgmii_tx #(
    parameter int CLK_DIV   = 2,
    parameter bit FCS_EN    = 1'b1,
    parameter int IPG_BYTES = 12
) (
    input  logic       clk,
    input  logic       SW0,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       rgm_tx_clk,
    output logic       rgm_tx_en,
    output logic [3:0] rgm_tx_d,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int DW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IPG_SLOTS = 2 * IPG_BYTES;
    localparam int CW        = (IPG_SLOTS > 8) ? $clog2(IPG_SLOTS) : 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_FCS,
        S_IPG
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hi_q, hi_d;
    logic [7:0]    byte_q, byte_d;
    logic          last_q, last_d;
    logic          bad_q, bad_d;
    logic [31:0]   crc_q, crc_d;
    logic          txc_q, txc_d;
    logic          en_q, en_d;
    logic [3:0]    d_q, d_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          tick, half;
    logic          go_pre, go_end, go_ipg, end_bad;
    logic [31:0]   fcs_word, end_word;
    logic [7:0]    cur_byte, nxt_fcs;

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] sel_byte(input logic [31:0] w,
                                            input logic [1:0]  idx);
        logic [7:0] r;
        unique case (idx)
            2'd0:    r = w[7:0];
            2'd1:    r = w[15:8];
            2'd2:    r = w[23:16];
            default: r = w[31:24];
        endcase
        return r;
    endfunction

    assign tick = (div_q == DW'(CLK_DIV - 1));
    assign half = (div_q == DW'(CLK_DIV / 2 - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;
    assign txc_d = half ? ~txc_q : txc_q;

    // The strobe sits on the last clk of a high-nibble slot so the
    // accepted byte's low nibble goes out on the very next slot start.
    assign in_ready = tick & hi_q &
                      (((state_q == S_PRE) & (cnt_q == CW'(7))) |
                       ((state_q == S_PAY) & ~last_q));
    assign underrun = in_ready & ~in_valid;

    assign fcs_word = bad_q ? crc_q : ~crc_q;
    assign nxt_fcs  = sel_byte(fcs_word, cnt_q[1:0] + 2'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        byte_d   = byte_q;
        last_d   = last_q;
        bad_d    = bad_q;
        crc_d    = crc_q;
        en_d     = en_q;
        d_d      = d_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        go_pre   = 1'b0;
        go_end   = 1'b0;
        go_ipg   = 1'b0;
        end_bad  = bad_q;
        end_word = 32'h0;
        cur_byte = 8'h00;

        unique case (state_q)
            S_PRE:   cur_byte = (cnt_q == CW'(7)) ? 8'hD5 : 8'h55;
            S_PAY:   cur_byte = byte_q;
            S_FCS:   cur_byte = sel_byte(fcs_word, cnt_q[1:0]);
            default: cur_byte = 8'h00;
        endcase

        if (tick) begin
            unique case (state_q)
                S_IDLE: go_pre = in_valid & ~txc_q;
                S_IPG: begin
                    if (cnt_q == CW'(IPG_SLOTS - 1)) begin
                        if (in_valid & ~txc_q) begin
                            go_pre = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (!hi_q) begin
                        hi_d = 1'b1;
                        d_d  = cur_byte[7:4];
                    end else begin
                        hi_d = 1'b0;
                        if (in_ready) begin
                            if (in_valid) begin
                                state_d = S_PAY;
                                byte_d  = in_data;
                                last_d  = in_last;
                                crc_d   = crc_step(crc_q, in_data);
                                d_d     = in_data[3:0];
                            end else begin
                                end_bad = 1'b1;
                                bad_d   = 1'b1;
                                go_end  = 1'b1;
                            end
                        end else if (state_q == S_PRE) begin
                            cnt_d = cnt_q + 1'b1;
                            d_d   = 4'h5;
                        end else if (state_q == S_PAY) begin
                            go_end = 1'b1;
                        end else if (cnt_q == CW'(3)) begin
                            go_ipg = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            d_d   = nxt_fcs[3:0];
                        end
                    end
                end
            endcase
        end

        if (go_end) begin
            if (FCS_EN) begin
                // An underrun sends the raw register: a guaranteed-bad FCS.
                end_word = end_bad ? crc_q : ~crc_q;
                state_d  = S_FCS;
                cnt_d    = '0;
                d_d      = end_word[3:0];
            end else begin
                go_ipg = 1'b1;
            end
        end

        if (go_ipg) begin
            state_d = S_IPG;
            cnt_d   = '0;
            hi_d    = 1'b0;
            en_d    = 1'b0;
            d_d     = 4'h0;
            done_d  = 1'b1;
        end

        if (go_pre) begin
            state_d = S_PRE;
            cnt_d   = '0;
            hi_d    = 1'b0;
            en_d    = 1'b1;
            d_d     = 4'h5;
            crc_d   = 32'hFFFFFFFF;
            bad_d   = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge SW0) begin
        if (SW0) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            bad_q   <= 1'b0;
            crc_q   <= 32'hFFFFFFFF;
            txc_q   <= 1'b0;
            en_q    <= 1'b0;
            d_q     <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            bad_q   <= bad_d;
            crc_q   <= crc_d;
            txc_q   <= txc_d;
            en_q    <= en_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rgm_tx_clk = txc_q;
    assign rgm_tx_en  = en_q;
    assign rgm_tx_d   = d_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_rgmii_tx.sv
// Scoreboard bench for rgmii_tx: default instance plus a CLK_DIV=4,
// FCS_EN=0 instance; monitors rebuild bytes from TXC edges.
module tb_rgmii_tx;

    logic       clk = 1'b0;
    logic       SW0;
    logic [7:0] id1, id2;
    logic       iv1, il1, iv2, il2;
    logic       rdy1, txc1, en1, busy1, fd1, ur1;
    logic       rdy2, txc2, en2, busy2, fd2, ur2;
    logic [3:0] td1, td2;

    always #5 clk = ~clk;

    rgmii_tx dut1 (
        .clk(clk), .SW0(SW0), .in_data(id1), .in_valid(iv1),
        .in_last(il1), .in_ready(rdy1), .rgm_tx_clk(txc1),
        .rgm_tx_en(en1), .rgm_tx_d(td1), .busy(busy1),
        .frame_done(fd1), .underrun(ur1)
    );

    rgmii_tx #(.CLK_DIV(4), .FCS_EN(1'b0), .IPG_BYTES(12)) dut2 (
        .clk(clk), .SW0(SW0), .in_data(id2), .in_valid(iv2),
        .in_last(il2), .in_ready(rdy2), .rgm_tx_clk(txc2),
        .rgm_tx_en(en2), .rgm_tx_d(td2), .busy(busy2),
        .frame_done(fd2), .underrun(ur2)
    );

    int n_chk = 0;
    int n_fail = 0;
    int sel = 0;
    bit mon_on = 1'b0;
    bit t6_on = 1'b0;
    logic [7:0] pay [16];
    logic [7:0] exp1 [$];
    logic [7:0] exp2 [$];
    int len1 [$];
    int len2 [$];
    int last_gap1 = 0;
    int rdy_cnt1 = 0, ur_cnt1 = 0, fd_cnt1 = 0;
    int viol2 = 0, perr2 = 0, rises2 = 0;

    function automatic void chk(string name, int act, int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic void note_fail(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endfunction

    function automatic logic [31:0] crc32(int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++)
                c = (c[0] ^ pay[k][i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return ~c;
    endfunction

    task automatic push_b(input int s, input logic [7:0] b);
        if (s == 0) exp1.push_back(b);
        else exp2.push_back(b);
    endtask

    // mode: 0 no FCS, 1 good FCS, 2 complemented FCS
    task automatic push_frame(input int s, input int n, input int mode);
        logic [31:0] f;
        for (int i = 0; i < 7; i++) push_b(s, 8'h55);
        push_b(s, 8'hD5);
        for (int i = 0; i < n; i++) push_b(s, pay[i]);
        f = (mode == 2) ? ~crc32(n) : crc32(n);
        if (mode != 0)
            for (int i = 0; i < 4; i++) push_b(s, f[8*i +: 8]);
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic l);
        if (sel == 0) begin iv1 = v; id1 = d; il1 = l; end
        else begin iv2 = v; id2 = d; il2 = l; end
    endtask

    task automatic send(input int n, input int drop, input bit tog, input bit hold);
        int i;
        int cyc;
        logic r;
        i = 0;
        cyc = 0;
        set_in(1'b1, pay[0], n == 1);
        while (i < n) begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                note_fail("send_timeout");
                break;
            end
            r = (sel == 0) ? rdy1 : rdy2;
            if (r) begin
                if (i == drop) begin
                    set_in(1'b0, pay[i], 1'b0);
                    @(posedge clk);
                    #1;
                    break;
                end
                set_in(1'b1, pay[i], i == n - 1);
                @(posedge clk);
                #1;
                i++;
                if (i < n) set_in(tog ? 1'($urandom_range(0, 1)) : 1'b1, pay[i], i == n - 1);
                else if (!hold) set_in(1'b0, 8'h00, 1'b0);
            end else if (tog && i > 0) begin
                set_in(1'($urandom_range(0, 1)), pay[i], i == n - 1);
            end
        end
    endtask

    task automatic wait_idle(input int s);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (((s == 0) ? busy1 : busy2) && c < 20000);
        if (c >= 20000) note_fail("idle_timeout");
        repeat (10) @(negedge clk);
    endtask

    task automatic rise_time(output time t);
        logic p;
        int c;
        p = txc1;
        c = 0;
        t = 0;
        while (c < 1000) begin
            @(negedge clk);
            c++;
            if (txc1 && !p) begin
                t = $time;
                break;
            end
            p = txc1;
        end
        if (c >= 1000) note_fail("txc_rise_timeout");
    endtask

    always @(negedge clk) begin
        if (rdy1) rdy_cnt1++;
        if (ur1) ur_cnt1++;
        if (fd1) fd_cnt1++;
    end

    // Monitor for dut1: low nibble on TXC rise, high nibble on TXC fall.
    bit act1 = 0, lo_en1 = 0;
    int slots1 = 0, gap1 = 0;
    logic [3:0] lo1;
    always begin
        @(txc1);
        #1;
        if (!mon_on) begin
            act1 = 0; lo_en1 = 0; gap1 = 0;
        end else begin
            if (en1) begin
                if (!act1) begin act1 = 1; last_gap1 = gap1; slots1 = 0; end
                slots1++;
            end else begin
                if (act1) begin
                    act1 = 0;
                    gap1 = 0;
                    if (len1.size() == 0) note_fail("len1_unexpected_frame");
                    else chk("frame_len1", slots1, len1.pop_front());
                end
                gap1++;
            end
            if (txc1) begin
                lo1 = td1; lo_en1 = en1;
            end else if (en1 && lo_en1) begin
                if (exp1.size() == 0) note_fail("byte1_unexpected");
                else chk("byte1", int'({td1, lo1}), int'(exp1.pop_front()));
            end
        end
    end

    bit act2 = 0, lo_en2 = 0;
    int slots2 = 0;
    logic [3:0] lo2;
    always begin
        @(txc2);
        #1;
        if (!mon_on) begin
            act2 = 0; lo_en2 = 0;
        end else begin
            if (en2) begin
                if (!act2) begin act2 = 1; slots2 = 0; end
                slots2++;
            end else if (act2) begin
                act2 = 0;
                if (len2.size() == 0) note_fail("len2_unexpected_frame");
                else chk("frame_len2", slots2, len2.pop_front());
            end
            if (txc2) begin
                lo2 = td2; lo_en2 = en2;
            end else if (en2 && lo_en2) begin
                if (exp2.size() == 0) note_fail("byte2_unexpected");
                else chk("byte2", int'({td2, lo2}), int'(exp2.pop_front()));
            end
        end
    end

    // dut2 timing: outputs move CLK_DIV/2 clk after a TXC edge, TXC period 8.
    logic p_txc2 = 0, p_en2 = 0;
    logic [3:0] p_td2 = 0;
    int since2 = 0, cyc2 = 0, last_rise2 = 0;
    always @(negedge clk) begin
        cyc2++;
        if (txc2 != p_txc2) begin
            since2 = 0;
            if (txc2) begin
                if (t6_on && rises2 > 0 && cyc2 - last_rise2 != 8) perr2++;
                if (t6_on) rises2++;
                last_rise2 = cyc2;
            end
        end else begin
            since2++;
        end
        if (t6_on && (td2 != p_td2 || en2 != p_en2) && since2 != 2) viol2++;
        p_txc2 = txc2;
        p_td2 = td2;
        p_en2 = en2;
    end

    initial begin
        time t0, t1;
        int c, rd0, ur0, fd0;
        SW0 = 1'b1;
        iv1 = 0; id1 = 0; il1 = 0;
        iv2 = 0; id2 = 0; il2 = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({rdy1, txc1, en1, td1, busy1, fd1, ur1}), 0);
        SW0 = 1'b0;

        // T1: reset in the middle of the payload
        sel = 0;
        set_in(1'b1, 8'hAA, 1'b0);
        c = 0;
        rd0 = rdy_cnt1;
        while (rdy_cnt1 - rd0 < 2 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 2000) note_fail("t1_ready_timeout");
        repeat (3) @(negedge clk);
        SW0 = 1'b1;
        #1;
        chk("t1_midframe_reset", int'({rdy1, txc1, en1, td1, busy1, fd1, ur1}), 0);
        set_in(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        SW0 = 1'b0;
        rise_time(t0);
        rise_time(t1);
        chk("t1_txc_period_ns", int'(t1 - t0), 40);
        repeat (10) @(negedge clk);
        mon_on = 1'b1;

        // T2: "123456789" with literal FCS 26 39 F4 CB
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        push_frame(0, 9, 0);
        push_b(0, 8'h26); push_b(0, 8'h39); push_b(0, 8'hF4); push_b(0, 8'hCB);
        len1.push_back(42);
        fd0 = fd_cnt1;
        send(9, -1, 1'b0, 1'b0);
        wait_idle(0);
        chk("t2_frame_done", fd_cnt1 - fd0, 1);

        // T3: in_valid toggled between strobes
        push_frame(0, 9, 1);
        len1.push_back(42);
        rd0 = rdy_cnt1;
        ur0 = ur_cnt1;
        send(9, -1, 1'b1, 1'b0);
        wait_idle(0);
        chk("t3_ready_count", rdy_cnt1 - rd0, 9);
        chk("t3_underruns", ur_cnt1 - ur0, 0);

        // T4: underrun at byte 3
        push_frame(0, 3, 2);
        len1.push_back(30);
        ur0 = ur_cnt1;
        fd0 = fd_cnt1;
        send(9, 3, 1'b0, 1'b0);
        wait_idle(0);
        chk("t4_underrun", ur_cnt1 - ur0, 1);
        chk("t4_frame_done", fd_cnt1 - fd0, 1);

        // T5: back-to-back 1-byte frames, valid held high
        pay[0] = 8'hA5;
        push_frame(0, 1, 1);
        len1.push_back(26);
        send(1, -1, 1'b0, 1'b1);
        pay[0] = 8'h3C;
        push_frame(0, 1, 1);
        len1.push_back(26);
        send(1, -1, 1'b0, 1'b0);
        wait_idle(0);
        chk("t5_ipg_slots", last_gap1, 24);

        // T6: CLK_DIV=4, no FCS
        sel = 1;
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        push_frame(1, 9, 0);
        len2.push_back(34);
        t6_on = 1'b1;
        send(9, -1, 1'b0, 1'b0);
        wait_idle(1);
        t6_on = 1'b0;
        chk("t6_txd_off_slot_start", viol2, 0);
        chk("t6_txc_period_err", perr2, 0);
        chk("t6_txc_seen", int'(rises2 > 20), 1);

        chk("exp1_left", exp1.size() + len1.size(), 0);
        chk("exp2_left", exp2.size() + len2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
